pc_stack: RTL and testbench

PC_STACK -- requirements
Module: pc_stack

---
 rtl/pc_stack.sv | 122 ++++++++++++
 tb/tb_pc_stack.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_stack.sv
// rtl/pc_stack.sv - program counter with return-address stack; PC_STACK_GUARD_EN selects overflow/underflow guarding
module pc_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     inc,
  input  logic                     load,
  input  logic [WIDTH-1:0]         load_addr,
  input  logic                     call,
  input  logic [WIDTH-1:0]         call_addr,
  input  logic                     ret,
  output logic [WIDTH-1:0]         pc,
  output logic [$clog2(DEPTH):0]   sp,
  output logic                     empty,
  output logic                     full,
  output logic                     err
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = AW + 1;
  localparam logic [SW-1:0] SP_FULL = SW'(DEPTH);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [SW-1:0]    sp_q, sp_d;
  logic [WIDTH-1:0] stack_q [DEPTH];
  logic [WIDTH-1:0] stack_d [DEPTH];
  logic [WIDTH-1:0] ret_addr;
  logic [SW-1:0]    sp_m1;
  logic             is_empty;
  logic             is_full;
`ifdef PC_STACK_GUARD_EN
  logic             err_q, err_d;
`endif

  assign is_empty = (sp_q == '0);
  assign is_full  = (sp_q == SP_FULL);
  assign ret_addr = pc_q + WIDTH'(1);
  assign sp_m1    = sp_q - SW'(1);

  // Next-state decode: one operation per cycle, call > ret > load > inc > hold.
  always_comb begin
    pc_d    = pc_q;
    sp_d    = sp_q;
    stack_d = stack_q;
`ifdef PC_STACK_GUARD_EN
    err_d   = err_q;
`endif
    if (call) begin
      if (!is_full) begin
        stack_d[sp_q[AW-1:0]] = ret_addr;
        sp_d                  = sp_q + SW'(1);
        pc_d                  = call_addr;
      end else begin
`ifdef PC_STACK_GUARD_EN
        // Overflow is refused outright; only the sticky flag records it.
        err_d = 1'b1;
`else
        // Overflow drops the oldest return address so the newest nest still returns.
        for (int i = 0; i < DEPTH - 1; i++) begin
          stack_d[i] = stack_q[i+1];
        end
        stack_d[DEPTH-1] = ret_addr;
        pc_d             = call_addr;
`endif
      end
    end else if (ret) begin
      if (!is_empty) begin
        pc_d = stack_q[sp_m1[AW-1:0]];
        sp_d = sp_m1;
      end else begin
`ifdef PC_STACK_GUARD_EN
        err_d = 1'b1;
`else
        pc_d = '0;
`endif
      end
    end else if (load) begin
      pc_d = load_addr;
    end else if (inc) begin
      pc_d = pc_q + WIDTH'(1);
    end
  end

  // Program counter and stack pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= '0;
      sp_q <= '0;
    end else begin
      pc_q <= pc_d;
      sp_q <= sp_d;
    end
  end

  // Stack storage is not reset; entries are only read after being pushed.
  always_ff @(posedge clk) begin
    stack_q <= stack_d;
  end

`ifdef PC_STACK_GUARD_EN
  // Sticky misuse flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign pc    = pc_q;
  assign sp    = sp_q;
  assign empty = is_empty;
  assign full  = is_full;

endmodule

// File: tb/tb_pc_stack.sv
// tb/tb_pc_stack.sv - directed scoreboard bench for pc_stack
module tb_pc_stack;

  typedef struct packed {
    logic [15:0] pc;
    logic [3:0]  sp;
    logic        empty;
    logic        full;
    logic        err;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inc, load, call, ret;
  logic [15:0] load_addr, call_addr;
  logic [15:0] pc;
  logic [3:0]  sp;
  logic        empty, full, err;

  int n_vec = 0;
  int n_mis = 0;

  obs_t  exp_q [$];
  string tag_q [$];

  logic [15:0] m_pc;
  logic        m_err;
  logic [15:0] m_stk [$];

`ifdef PC_STACK_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  pc_stack #(.WIDTH(16), .DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .inc(inc), .load(load), .load_addr(load_addr),
    .call(call), .call_addr(call_addr), .ret(ret), .pc(pc), .sp(sp),
    .empty(empty), .full(full), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  function automatic obs_t model_obs();
    obs_t o;
    o.pc    = m_pc;
    o.sp    = 4'(m_stk.size());
    o.empty = (m_stk.size() == 0);
    o.full  = (m_stk.size() == 8);
    o.err   = m_err;
    return o;
  endfunction

  task automatic model_reset();
    m_pc  = 16'h0000;
    m_err = 1'b0;
    m_stk.delete();
  endtask

  task automatic model_op(input logic i_inc, input logic i_load, input logic [15:0] la,
                          input logic i_call, input logic [15:0] ca, input logic i_ret);
    if (i_call) begin
      if (m_stk.size() == 8) begin
        if (GUARD) m_err = 1'b1;
        else begin
          void'(m_stk.pop_front());
          m_stk.push_back(m_pc + 16'h1);
          m_pc = ca;
        end
      end else begin
        m_stk.push_back(m_pc + 16'h1);
        m_pc = ca;
      end
    end else if (i_ret) begin
      if (m_stk.size() == 0) begin
        if (GUARD) m_err = 1'b1;
        else m_pc = 16'h0000;
      end else begin
        m_pc = m_stk.pop_back();
      end
    end else if (i_load) begin
      m_pc = la;
    end else if (i_inc) begin
      m_pc = m_pc + 16'h1;
    end
  endtask

  task automatic compare_out();
    obs_t  o, e;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    o = {pc, sp, empty, full, err};
    n_vec++;
    assert (o === e) else begin
      n_mis++;
      $error("FAIL %s: observed pc=%h sp=%0d empty=%b full=%b err=%b, expected pc=%h sp=%0d empty=%b full=%b err=%b",
             t, o.pc, o.sp, o.empty, o.full, o.err, e.pc, e.sp, e.empty, e.full, e.err);
    end
  endtask

  task automatic check_val(input string t, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_mis++;
      $error("FAIL %s: observed %h, expected %h", t, obs, expv);
    end
  endtask

  task automatic step(input string t, input logic i_inc, input logic i_load, input logic [15:0] la,
                      input logic i_call, input logic [15:0] ca, input logic i_ret);
    model_op(i_inc, i_load, la, i_call, ca, i_ret);
    exp_q.push_back(model_obs());
    tag_q.push_back(t);
    inc = i_inc; load = i_load; load_addr = la;
    call = i_call; call_addr = ca; ret = i_ret;
    @(posedge clk);
    #1;
    inc = 1'b0; load = 1'b0; call = 1'b0; ret = 1'b0;
    compare_out();
  endtask

  initial begin
    rst_n = 1'b0;
    inc = 1'b0; load = 1'b0; call = 1'b0; ret = 1'b0;
    load_addr = '0; call_addr = '0;
    model_reset();
    #23;
    exp_q.push_back(model_obs());
    tag_q.push_back("reset_state");
    compare_out();
    rst_n = 1'b1;

    step("inc1", 1, 0, 16'h0, 0, 16'h0, 0);
    step("inc2", 1, 0, 16'h0, 0, 16'h0, 0);
    step("inc3", 1, 0, 16'h0, 0, 16'h0, 0);
    check_val("inc3_pc", {16'h0, pc}, 32'h3);

    step("load_0010", 0, 1, 16'h0010, 0, 16'h0, 0);
    step("call_0200", 0, 0, 16'h0, 1, 16'h0200, 0);
    check_val("call_pc", {16'h0, pc}, 32'h0200);
    step("ret_0011", 0, 0, 16'h0, 0, 16'h0, 1);
    check_val("ret_pc", {16'h0, pc}, 32'h0011);

    step("load_ffff", 0, 1, 16'hFFFF, 0, 16'h0, 0);
    step("inc_wrap", 1, 0, 16'h0, 0, 16'h0, 0);
    check_val("wrap_pc_err", {15'h0, err, pc}, 32'h0);

    step("call_ret_load", 0, 1, 16'h1234, 1, 16'h0040, 1);
    check_val("prio_pc_sp", {12'h0, sp, pc}, {12'h0, 4'd1, 16'h0040});
    step("ret_after_prio", 0, 0, 16'h0, 0, 16'h0, 1);
    step("ret_over_load", 0, 1, 16'h5555, 0, 16'h0, 0);
    step("hold", 0, 0, 16'h0, 0, 16'h0, 0);
    step("load_over_inc", 1, 1, 16'h0000, 0, 16'h0, 0);

    for (int i = 0; i < 8; i++) begin
      step("fill_call", 0, 0, 16'h0, 1, 16'h0100 + 16'(i * 16), 0);
    end
    check_val("fill_full_sp", {27'h0, full, sp}, {27'h0, 1'b1, 4'd8});
    step("call_at_full", 0, 0, 16'h0, 1, 16'h0200, 0);
`ifdef PC_STACK_GUARD_EN
    check_val("ovf_guard", {12'h0, err, full, sp[1:0], pc}, {12'h0, 1'b1, 1'b1, 2'b00, 16'h0170});
`else
    check_val("ovf_shift", {12'h0, err, full, sp[1:0], pc}, {12'h0, 1'b0, 1'b1, 2'b00, 16'h0200});
`endif
    for (int i = 0; i < 8; i++) begin
      step("drain_ret", 0, 0, 16'h0, 0, 16'h0, 1);
    end
`ifdef PC_STACK_GUARD_EN
    check_val("last_pop", {16'h0, pc}, 32'h0001);
`else
    check_val("last_pop", {16'h0, pc}, 32'h0101);
`endif
    step("ret_at_empty", 0, 0, 16'h0, 0, 16'h0, 1);
`ifdef PC_STACK_GUARD_EN
    check_val("unf_guard", {15'h0, err, pc}, {15'h0, 1'b1, 16'h0001});
`else
    check_val("unf_zero", {15'h0, err, pc}, {15'h0, 1'b0, 16'h0000});
`endif
    step("err_sticky", 1, 0, 16'h0, 0, 16'h0, 0);

    step("pre_rst_load", 0, 1, 16'h0ABC, 0, 16'h0, 0);
    step("pre_rst_call", 0, 0, 16'h0, 1, 16'h0300, 0);
    inc = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    exp_q.push_back(model_obs());
    tag_q.push_back("async_reset");
    compare_out();
    #1;
    rst_n = 1'b1;
    step("first_edge_after_rst", 1, 0, 16'h0, 0, 16'h0, 0);
    check_val("post_rst_pc", {16'h0, pc}, 32'h0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
